// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard control slice.
package pipe_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam int unsigned MUL_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF = 32;
  localparam logic [4:0]  REG_ZERO    = 5'd0;

  // Counter width able to hold (max latency - 1); never narrower than 1 bit.
  function automatic int unsigned md_cnt_width(input int unsigned mul_lat,
                                               input int unsigned div_lat);
    int unsigned m;
    m = (mul_lat > div_lat) ? mul_lat : div_lat;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/md_tracker.sv
// Mult/div occupancy tracker: idle/busy FSM with a latency down-counter.
module md_tracker
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam int unsigned CW = md_cnt_width(MUL_LAT, DIV_LAT);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  md_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        // A start here is illegal and deliberately ignored.
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Masked during reset so an abandoned operation never reports busy or done.
  assign busy = (state_q == MD_BUSY) && !rst;
  assign done = busy && (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage core: load-use, mult/div and taken-branch hazards.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_md_use,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_md_start,
  input  logic             ex_md_is_div,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             lu, mdh, stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  md_tracker #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_tracker (
    .clk    (clk),
    .rst    (rst),
    .start  (ex_md_start),
    .is_div (ex_md_is_div),
    .busy   (md_busy),
    .done   (md_done)
  );

  always_comb begin
    lu = ex_mem_read && (ex_rt != REG_ZERO) &&
         ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    // Released in the done cycle: HI/LO is written as the consumer enters EX.
    mdh   = id_md_use && (ex_md_start || (md_busy && !md_done));
    stall = (lu || mdh) && !branch_taken && !rst;

    pc_en       = !stall;
    if_id_en    = !stall;
    if_id_flush = branch_taken && !rst;
    id_ex_flush = (stall || branch_taken) && !rst;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline stall/flush scheduler for the 5-stage MIPS core.
- Works alongside the combinational forwarding select logic and covers the hazards forwarding cannot resolve:
  - load-use hazards;
  - HI/LO reads or new mult/div issues while the multi-cycle mult/div unit is busy;
  - wrong-path instructions after a taken branch resolved in EX.
- Drives the PC enable, the IF/ID enable and flush, and the ID/EX bubble insertion. Also tracks mult/div occupancy and keeps a stall-cycle performance counter.

Parameters:
- MUL_LAT, 4, mult latency in cycles (>=1), counted from the EX issue cycle to the md_done cycle.
- DIV_LAT, 32, div latency in cycles (>=1).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_md_use  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  5  load destination register in EX.
- ex_md_start  in  1  mult/div issuing in EX this cycle.
- ex_md_is_div  in  1  qualifies ex_md_start: 1 = div, 0 = mult.
- branch_taken  in  1  branch/jump resolved taken in EX.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  clear IF/ID to a nop.
- id_ex_flush  out  1  load a bubble into ID/EX.
- md_busy  out  1  mult/div unit occupied.
- md_done  out  1  one-cycle pulse when the HI/LO result is written.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to MD_IDLE; latency counter = 0; stall_cnt = 0.
  - During rst: pc_en = 1, if_id_en = 1, if_id_flush = 0, id_ex_flush = 0, md_busy = 0, md_done = 0.
  - rst mid-busy abandons the operation with no md_done pulse.
- Load-use hazard, combinational:
  - lu = ex_mem_read && ex_rt != 0 && ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt)).
  - Costs exactly 1 stall cycle. The next cycle resolves it through MEM->EX forwarding.
- Mult/div FSM, two states (MD_IDLE, MD_BUSY), down-counter cnt sized to clog2(DIV_LAT):
  - MD_IDLE: on ex_md_start, load cnt = (ex_md_is_div ? DIV_LAT : MUL_LAT) - 1 and go to MD_BUSY.
  - MD_BUSY: if cnt == 0, assert md_done this cycle and go to MD_IDLE next cycle; otherwise cnt decrements.
  - Issue in cycle S gives md_done in cycle S+LAT.
  - md_busy = (state == MD_BUSY).
  - ex_md_start while in MD_BUSY is ignored. It cannot occur legally; the bench flags it as an error.
- Mult/div hazard:
  - mdh = id_md_use && (ex_md_start || (md_busy && !md_done)).
  - The stall is released in the md_done cycle, so the consumer enters EX after HI/LO has been written.
  - A dependent instruction in ID at cycle S therefore stalls LAT cycles.
- Stall: stall = (lu || mdh) && !branch_taken.
  - pc_en = !stall; if_id_en = !stall; id_ex_flush = stall || branch_taken; if_id_flush = branch_taken.
- Priority: a taken branch beats any stall, because the ID instruction is wrong-path.
  - pc_en = 1 so the target is fetched; IF/ID and ID/EX are both flushed.
- A taken branch does not affect an in-flight mult/div; the older instruction commits.
- lu and mdh asserted together give a single stall cycle. The stall persists while either holds.
- stall_cnt increments on every cycle with stall == 1 and saturates at 2^CNT_W - 1 with no wrap.
- All outputs except the FSM-derived ones (md_busy, md_done) are combinational from the inputs and current state. Zero added latency.

Decomposition:
- pipe_pkg holds:
  - md_state_t enum (MD_IDLE, MD_BUSY);
  - the default MUL_LAT/DIV_LAT constants;
  - the REG_ZERO constant 5'd0.
- Sub-module md_tracker holds the FSM plus down-counter. Its interface: clk, rst, start, is_div → busy, done.
- Hazard equations and stall_cnt stay in hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; next cycle pc_en=1; stall_cnt=1.
- Zero register: same stimulus with ex_rt=0, id_rs=0 → no stall, pc_en=1.
- Div then mflo: ex_md_start=1, ex_md_is_div=1, id_md_use=1 at cycle S → stall cycles S..S+31; md_done=1 at S+32; pc_en=1 at S+32; md_busy=0 at S+33; stall_cnt=32.
- Branch priority: load-use condition plus branch_taken=1 → pc_en=1, if_id_flush=1, id_ex_flush=1; stall_cnt unchanged.
- Reset mid-mult: mult issued, rst=1 at S+2 → next cycle md_busy=0, cnt=0, stall_cnt=0; md_done never pulses.
- Saturation: CNT_W=4, hold a stall condition for 20 cycles → stall_cnt holds at 15.
